// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline stage.
// Holds the occupancy state encoding, the default bundle and counter widths,
// and a helper that converts a state into its entry count.
package ctrl_pipe_pkg;

  localparam int DEF_CTRL_W = 3;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // The state encoding doubles as the entry count, but keep the mapping
  // explicit so a re-encoding of the enum cannot silently break occupancy.
  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage_sat_cnt.sv
// Saturating up-counter with a small increment amount.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, clears the count
//   amount - value added on each edge (0..3); 0 holds the count
//   count  - current count, sticks at 2^W-1 once reached
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   amount,
  output logic [W-1:0] count
);

  // Two guard bits let the sum exceed the maximum without wrapping, so the
  // saturation compare also works for very narrow counters.
  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

  logic [W+1:0] sum;

  assign sum = {2'b00, count} + {{W{1'b0}}, amount};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= (sum > MAX) ? MAX[W-1:0] : sum[W-1:0];
    end
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Control-bundle pipeline stage with optional two-entry skid buffer.
// Ports:
//   clk, reset           - clock and asynchronous active-high reset
//   in_valid/in_ctrl     - upstream bundle offer
//   in_ready             - stage accepts the bundle this cycle
//   out_valid/out_ctrl   - downstream bundle (BUBBLE_VAL when nothing held)
//   out_ready            - downstream consumes the bundle this cycle
//   flush                - synchronous kill of held and incoming entries
//   occupancy            - number of entries held (0..2)
//   flush_cnt            - saturating count of entries discarded by flush
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int                CTRL_W     = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = '0,
  parameter int                SKID       = 1,
  parameter int                CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t            state;
  state_t            next_state;
  logic [CTRL_W-1:0] main_q;
  logic [CTRL_W-1:0] skid_q;
  logic              rdy_q;
  logic              push;
  logic              pop;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [1:0]        flush_inc;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // With the skid entry, ready is a pure register so no combinational path
  // runs from out_ready to in_ready. Without it, ready must look at out_ready
  // so a full single entry can still stream. rdy_q also holds ready low
  // during reset and until the first edge afterwards.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign in_ready = rdy_q & ((state == EMPTY) | out_ready);
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? main_q : BUBBLE_VAL;
  assign occupancy = occ_of(state);

  // Entries lost to a flush: everything held plus a push arriving that cycle.
  assign flush_inc = flush ? (occupancy + {1'b0, push}) : 2'd0;

  // Next-state and register-load decode; flush overrides everything.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            if (SKID != 0) begin
              next_state = TWO;
              load_skid  = 1'b1;
            end
          end else if (!push && pop) begin
            next_state = EMPTY;
          end else if (push && pop) begin
            load_main_in = 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            next_state     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // State, data registers and the registered ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
      rdy_q  <= 1'b0;
    end else begin
      state <= next_state;
      rdy_q <= (SKID != 0) ? (next_state != TWO) : 1'b1;
      if (flush) begin
        main_q <= BUBBLE_VAL;
        skid_q <= BUBBLE_VAL;
      end else begin
        if (load_main_in) begin
          main_q <= in_ctrl;
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= in_ctrl;
        end
      end
    end
  end

  sat_cnt #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .amount (flush_inc),
    .count  (flush_cnt)
  );

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Self-checking bench for ctrl_pipe_stage: default instance, a narrow-counter
// instance sharing its inputs, and a SKID=0 instance with its own inputs.
module tb_ctrl_pipe_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready, flush;
  logic [2:0] in_ctrl;
  logic       in_ready, out_valid;
  logic [2:0] out_ctrl;
  logic [1:0] occupancy;
  logic [7:0] flush_cnt;

  logic       s_in_ready, s_out_valid;
  logic [2:0] s_out_ctrl;
  logic [1:0] s_occupancy;
  logic [1:0] s_flush_cnt;

  logic       z_in_valid, z_out_ready, z_flush;
  logic [2:0] z_in_ctrl;
  logic       z_in_ready, z_out_valid;
  logic [2:0] z_out_ctrl;
  logic [1:0] z_occupancy;
  logic [7:0] z_flush_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] sb_q[$];
  logic [2:0] zq[$];
  int exp_cnt = 0;
  int exp_sat = 0;

  always #5 clk = ~clk;

  ctrl_pipe_stage u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(in_ready), .out_valid(out_valid), .out_ctrl(out_ctrl),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy),
    .flush_cnt(flush_cnt)
  );

  ctrl_pipe_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ctrl(s_out_ctrl),
    .out_ready(out_ready), .flush(flush), .occupancy(s_occupancy),
    .flush_cnt(s_flush_cnt)
  );

  ctrl_pipe_stage #(.SKID(0)) u_noskid (
    .clk(clk), .reset(reset), .in_valid(z_in_valid), .in_ctrl(z_in_ctrl),
    .in_ready(z_in_ready), .out_valid(z_out_valid), .out_ctrl(z_out_ctrl),
    .out_ready(z_out_ready), .flush(z_flush), .occupancy(z_occupancy),
    .flush_cnt(z_flush_cnt)
  );

  // Reference model of the skid-buffered stages for one edge: reports what
  // the outputs should be now, then applies push/pop/flush to the scoreboard.
  function automatic void model_edge(output logic e_rdy, output logic e_vld,
                                     output logic [2:0] e_val);
    bit e_push, e_pop;
    int inc;
    e_rdy  = (sb_q.size() < 2);
    e_vld  = (sb_q.size() > 0);
    e_val  = e_vld ? sb_q[0] : 3'd0;
    e_pop  = e_vld && out_ready;
    e_push = e_rdy && in_valid;
    if (flush) begin
      inc     = sb_q.size() + (e_push ? 1 : 0);
      exp_cnt = (exp_cnt + inc > 255) ? 255 : exp_cnt + inc;
      exp_sat = (exp_sat + inc > 3) ? 3 : exp_sat + inc;
      sb_q.delete();
    end else begin
      if (e_pop) void'(sb_q.pop_front());
      if (e_push) sb_q.push_back(in_ctrl);
    end
  endfunction

  // Samples DUT outputs before the edge, then advances past it.
  task automatic cycle(output logic rdy, output logic vld, output logic [2:0] val);
    rdy = in_ready;
    vld = out_valid;
    val = out_ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_ctrl = 3'd0; out_ready = 1'b0; flush = 1'b0;
    z_in_valid = 1'b0; z_in_ctrl = 3'd0; z_out_ready = 1'b0; z_flush = 1'b0;
    #2;
    tests_run++;
    if (out_valid !== 1'b0 || out_ctrl !== 3'd0 || in_ready !== 1'b0 ||
        occupancy !== 2'd0 || flush_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got vld=%b ctrl=%h rdy=%b occ=%0d cnt=%0d expected 0 0 0 0 0",
               out_valid, out_ctrl, in_ready, occupancy, flush_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1 || z_in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_edge: got %b/%b/%b expected 1/1/1",
               in_ready, s_in_ready, z_in_ready);
    end
  endtask

  task automatic test_stream();
    logic [2:0] vals[3];
    logic e_rdy, e_vld, rdy, vld;
    logic [2:0] e_val, val;
    vals[0] = 3'h5; vals[1] = 3'h3; vals[2] = 3'h6;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      in_ctrl  = (i < 3) ? vals[i] : 3'd0;
      model_edge(e_rdy, e_vld, e_val);
      cycle(rdy, vld, val);
      tests_run++;
      if (rdy !== e_rdy || vld !== e_vld || val !== e_val) begin
        tests_failed++;
        $display("[TB] FAIL stream_out[%0d]: got rdy=%b vld=%b ctrl=%h expected %b %b %h",
                 i, rdy, vld, val, e_rdy, e_vld, e_val);
      end
      if (i < 3) begin
        tests_run++;
        if (occupancy !== 2'd1 || out_ctrl !== vals[i]) begin
          tests_failed++;
          $display("[TB] FAIL stream_latency[%0d]: got occ=%0d ctrl=%h expected 1 %h",
                   i, occupancy, out_ctrl, vals[i]);
        end
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_ctrl !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drained: got vld=%b ctrl=%h expected 0 0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    logic e_rdy, e_vld, rdy, vld;
    logic [2:0] e_val, val;
    int budget;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 3'(i + 1);
      model_edge(e_rdy, e_vld, e_val);
      cycle(rdy, vld, val);
      tests_run++;
      if (rdy !== e_rdy || vld !== e_vld || val !== e_val) begin
        tests_failed++;
        $display("[TB] FAIL bp_fill[%0d]: got rdy=%b vld=%b ctrl=%h expected %b %b %h",
                 i, rdy, vld, val, e_rdy, e_vld, e_val);
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 3'h1) begin
      tests_failed++;
      $display("[TB] FAIL bp_full: got occ=%0d rdy=%b ctrl=%h expected 2 0 1",
               occupancy, in_ready, out_ctrl);
    end
    out_ready = 1'b1;
    budget = 0;
    while (sb_q.size() > 0 && budget < 6) begin
      model_edge(e_rdy, e_vld, e_val);
      cycle(rdy, vld, val);
      tests_run++;
      if (rdy !== e_rdy || vld !== e_vld || val !== e_val) begin
        tests_failed++;
        $display("[TB] FAIL bp_drain[%0d]: got rdy=%b vld=%b ctrl=%h expected %b %b %h",
                 budget, rdy, vld, val, e_rdy, e_vld, e_val);
      end
      if (budget == 0) begin
        tests_run++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
          tests_failed++;
          $display("[TB] FAIL bp_first_pop: got rdy=%b occ=%0d expected 1 1", in_ready, occupancy);
        end
      end
      budget++;
    end
    tests_run++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_timeout: got left=%0d vld=%b expected 0 0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    logic e_rdy, e_vld, rdy, vld;
    logic [2:0] e_val, val;
    bit       st_iv[5];
    bit       st_fl[5];
    logic [2:0] st_c[5];
    // Fill to two and flush with 7 offered (blocked by full), then hold one
    // and flush with 7 actually pushed.
    st_iv = '{1, 1, 1, 1, 1};
    st_fl = '{0, 0, 1, 0, 1};
    st_c  = '{3'h1, 3'h2, 3'h7, 3'h4, 3'h7};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = st_iv[i];
      in_ctrl  = st_c[i];
      flush    = st_fl[i];
      model_edge(e_rdy, e_vld, e_val);
      cycle(rdy, vld, val);
      flush = 1'b0;
      tests_run++;
      if (rdy !== e_rdy || vld !== e_vld || val !== e_val) begin
        tests_failed++;
        $display("[TB] FAIL flush_seq[%0d]: got rdy=%b vld=%b ctrl=%h expected %b %b %h",
                 i, rdy, vld, val, e_rdy, e_vld, e_val);
      end
      if (st_fl[i]) begin
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'd0 || occupancy !== 2'd0 ||
            flush_cnt !== 8'(exp_cnt) || s_flush_cnt !== 2'(exp_sat)) begin
          tests_failed++;
          $display("[TB] FAIL flush_after[%0d]: got vld=%b ctrl=%h occ=%0d cnt=%0d scnt=%0d expected 0 0 0 %0d %0d",
                   i, out_valid, out_ctrl, occupancy, flush_cnt, s_flush_cnt, exp_cnt, exp_sat);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model_edge(e_rdy, e_vld, e_val);
      cycle(rdy, vld, val);
      tests_run++;
      if (vld !== 1'b0 || val !== 3'd0 || rdy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL flush_no_ghost[%0d]: got vld=%b ctrl=%h rdy=%b expected 0 0 1",
                 i, vld, val, rdy);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic e_rdy, e_vld, rdy, vld;
    logic [2:0] e_val, val;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_ctrl  = (i == 0) ? 3'h3 : 3'h5;
      model_edge(e_rdy, e_vld, e_val);
      cycle(rdy, vld, val);
    end
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL midop_fill: got occ=%0d expected 2", occupancy);
    end
    #3;
    reset = 1'b1;
    #1;
    sb_q.delete();
    zq.delete();
    exp_cnt = 0;
    exp_sat = 0;
    tests_run++;
    if (out_valid !== 1'b0 || out_ctrl !== 3'd0 || occupancy !== 2'd0 || in_ready !== 1'b0 ||
        flush_cnt !== 8'd0 || s_flush_cnt !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset: got vld=%b ctrl=%h occ=%0d rdy=%b cnt=%0d scnt=%0d expected 0 0 0 0 0 0",
               out_valid, out_ctrl, occupancy, in_ready, flush_cnt, s_flush_cnt);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midop_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_saturation();
    logic e_rdy, e_vld, rdy, vld;
    logic [2:0] e_val, val;
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid = (i < 2);
        in_ctrl  = 3'(r + i + 1);
        flush    = (i == 2);
        model_edge(e_rdy, e_vld, e_val);
        cycle(rdy, vld, val);
        flush = 1'b0;
      end
      tests_run++;
      if (s_flush_cnt !== 2'(exp_sat) || flush_cnt !== 8'(exp_cnt)) begin
        tests_failed++;
        $display("[TB] FAIL sat_round[%0d]: got scnt=%0d cnt=%0d expected %0d %0d",
                 r, s_flush_cnt, flush_cnt, exp_sat, exp_cnt);
      end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (s_flush_cnt !== 2'd3 || s_occupancy !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: got scnt=%0d socc=%0d expected 3 0", s_flush_cnt, s_occupancy);
    end
  endtask

  task automatic test_back_to_back_noskid();
    logic e_rdy;
    logic [2:0] e_val;
    logic zr;
    logic [2:0] zc;
    bit e_pop, e_push;
    int budget;
    z_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      z_in_valid = (i < 8);
      z_in_ctrl  = 3'(i + 2);
      e_rdy  = (zq.size() == 0) || z_out_ready;
      e_val  = (zq.size() > 0) ? zq[0] : 3'd0;
      e_pop  = (zq.size() > 0) && z_out_ready;
      e_push = e_rdy && z_in_valid;
      zr = z_in_ready;
      zc = z_out_ctrl;
      @(posedge clk); #1;
      if (e_pop) void'(zq.pop_front());
      if (e_push) zq.push_back(z_in_ctrl);
      tests_run++;
      if (zr !== e_rdy || zc !== e_val || z_occupancy !== 2'(zq.size()) || z_occupancy > 2'd1) begin
        tests_failed++;
        $display("[TB] FAIL noskid_stream[%0d]: got rdy=%b ctrl=%h occ=%0d expected %b %h %0d",
                 i, zr, zc, z_occupancy, e_rdy, e_val, zq.size());
      end
    end
    z_out_ready = 1'b0;
    z_in_valid  = 1'b1;
    z_in_ctrl   = 3'h4;
    @(posedge clk); #1;
    zq.push_back(3'h4);
    tests_run++;
    if (z_in_ready !== 1'b0 || z_occupancy !== 2'd1 || z_out_ctrl !== 3'h4) begin
      tests_failed++;
      $display("[TB] FAIL noskid_block: got rdy=%b occ=%0d ctrl=%h expected 0 1 4",
               z_in_ready, z_occupancy, z_out_ctrl);
    end
    z_in_valid  = 1'b0;
    z_out_ready = 1'b1;
    budget = 0;
    while (z_out_valid === 1'b1 && budget < 5) begin
      @(posedge clk); #1;
      budget++;
    end
    tests_run++;
    if (z_out_valid !== 1'b0 || budget != 1) begin
      tests_failed++;
      $display("[TB] FAIL noskid_drain: got vld=%b cycles=%0d expected 0 1", z_out_valid, budget);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_saturation();
    test_back_to_back_noskid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
